bin2bcd_xs3_seq: RTL and testbench

Sequential, parametrised binary-to-decimal code converter using shift-and-add-3 (double-dabble).
- Converts an N-bit unsigned binary word into DIGITS packed decimal digits.
- Output is plain BCD or excess-3, selected per transaction.
- Successor to the combinational binary-to-excess-3 converter. Serves wide operands at low area, behind valid/ready handshakes, feeding display and serial-report datapaths.

---
 rtl/bin2bcd_xs3_seq.sv | 111 +++++++++++
 tb/tb_bin2bcd_xs3_seq.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_xs3_seq.sv
// Sequential binary to BCD / excess-3 converter (shift-and-add-3), one bit per clock,
// with valid/ready handshakes on the operand and result sides.
module bin2bcd_xs3_seq #(
  parameter int unsigned N      = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N-1:0]          din,
  input  logic                  xs3_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   dout,
  output logic                  busy
);

  localparam int unsigned DW = 4 * DIGITS;
  localparam int unsigned CW = $clog2(N + 1);

  // True when N is legal and DIGITS decimal digits can hold 2^N-1.
  function automatic bit cfg_ok();
    longint unsigned p;
    if (N < 1 || N > 32) return 1'b0;
    if (DIGITS >= 10) return 1'b1;
    p = 64'd1;
    for (int unsigned i = 0; i < DIGITS; i++) p = p * 64'd10;
    return p > ((64'd1 << N) - 64'd1);
  endfunction

  generate
    if (!cfg_ok()) begin : g_cfg_err
      $fatal(1, "bin2bcd_xs3_seq: illegal N/DIGITS combination");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state;
  logic            mode;
  logic [DW-1:0]   bcd;
  logic [N-1:0]    bin;
  logic [CW-1:0]   count;

  logic [DW-1:0]   adj;
  logic [DW-1:0]   bcd_nx;
  logic [N-1:0]    bin_nx;
  logic [DW-1:0]   xs3;

  // One double-dabble iteration plus the excess-3 view of its result.
  always_comb begin
    adj = '0;
    xs3 = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    end
    {bcd_nx, bin_nx} = {adj, bin} << 1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      xs3[4*i +: 4] = bcd_nx[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      dout      <= '0;
      bcd       <= '0;
      bin       <= '0;
      count     <= '0;
      mode      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            bin      <= din;
            mode     <= xs3_en;
            bcd      <= '0;
            count    <= CW'(N);
            state    <= SHIFT;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        SHIFT: begin
          bcd   <= bcd_nx;
          bin   <= bin_nx;
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            dout      <= mode ? xs3 : bcd_nx;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_xs3_seq.sv
// Directed bench for bin2bcd_xs3_seq: an N=8 instance for the directed cases and an
// N=12 instance driven with random operands against a decimal reference model.
module tb_bin2bcd_xs3_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        a_in_valid, a_in_ready, a_xs3_en, a_out_valid, a_out_ready, a_busy;
  logic [7:0]  a_din;
  logic [11:0] a_dout;

  logic        b_in_valid, b_in_ready, b_xs3_en, b_out_valid, b_out_ready, b_busy;
  logic [11:0] b_din;
  logic [15:0] b_dout;

  bin2bcd_xs3_seq #(.N(8), .DIGITS(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .din(a_din), .xs3_en(a_xs3_en), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .dout(a_dout), .busy(a_busy));

  bin2bcd_xs3_seq #(.N(12), .DIGITS(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .din(b_din), .xs3_en(b_xs3_en), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .dout(b_dout), .busy(b_busy));

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Decimal reference for the N=12 instance.
  function automatic logic [15:0] ref_dec(input logic [11:0] v, input logic x);
    int unsigned r;
    logic [15:0] res;
    r   = 32'(v);
    res = '0;
    for (int d = 0; d < 4; d++) begin
      res[4*d +: 4] = 4'(r % 10) + (x ? 4'd3 : 4'd0);
      r = r / 10;
    end
    return res;
  endfunction

  // Start on posedge+1 with in_ready high; full transaction with out_ready=1.
  task automatic run_a(input logic [7:0] d, input logic x, input logic [11:0] exp, input string tag);
    int cnt;
    a_out_ready = 1'b1;
    a_in_valid  = 1'b1;
    a_din       = d;
    a_xs3_en    = x;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    a_din      = ~d;
    a_xs3_en   = ~x;
    cnt = 0;
    while (!a_out_valid && cnt < 50) begin
      @(posedge clk); #1;
      cnt++;
      if (cnt == 4) check({tag, "_busy"}, 32'(a_busy), 32'd1);
    end
    check({tag, "_latency"}, 32'(cnt), 32'd8);
    check({tag, "_dout"}, 32'(a_dout), 32'(exp));
    check({tag, "_inrdy_done"}, 32'(a_in_ready), 32'd0);
    @(posedge clk); #1;
    check({tag, "_ovalid_fall"}, 32'(a_out_valid), 32'd0);
    check({tag, "_inrdy_back"}, 32'(a_in_ready), 32'd1);
  endtask

  logic [7:0]  ops  [3];
  logic [11:0] exps [3];
  logic [15:0] q [$];
  logic [15:0] e;

  initial begin
    int cnt, k_acc, k_out, last, cyc, sent, recvd;
    bit acc, fire_in, fire_out;

    rst_n = 1'b0;
    a_in_valid = 1'b0; a_din = '0; a_xs3_en = 1'b0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_din = '0; b_xs3_en = 1'b0; b_out_ready = 1'b1;
    #12;
    check("rst_in_ready", 32'(a_in_ready), 32'd1);
    check("rst_out_valid", 32'(a_out_valid), 32'd0);
    check("rst_busy", 32'(a_busy), 32'd0);
    check("rst_dout", 32'(a_dout), 32'd0);
    check("rst_b_dout", 32'(b_dout), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Plain and excess-3 conversions, including zero and max.
    run_a(8'd255, 1'b0, 12'h255, "t1_255");
    run_a(8'd255, 1'b1, 12'h588, "t2_255x");
    run_a(8'd0,   1'b1, 12'h333, "t2_0x");
    run_a(8'd99,  1'b0, 12'h099, "t2_99");
    run_a(8'd0,   1'b0, 12'h000, "t2_0");

    // Backpressure with ignored in_valid pulses during SHIFT and DONE.
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_din = 8'd128; a_xs3_en = 1'b0;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    cnt = 0;
    while (!a_out_valid && cnt < 50) begin
      a_in_valid = (cnt == 3);
      a_din = 8'd7;
      @(posedge clk); #1;
      cnt++;
    end
    a_in_valid = 1'b0;
    check("t3_latency", 32'(cnt), 32'd8);
    check("t3_dout", 32'(a_dout), 32'h128);
    for (int i = 0; i < 6; i++) begin
      a_in_valid = 1'b1; a_din = 8'd7;
      @(posedge clk); #1;
      check("t3_hold_valid", 32'(a_out_valid), 32'd1);
      check("t3_hold_dout", 32'(a_dout), 32'h128);
      check("t3_hold_inrdy", 32'(a_in_ready), 32'd0);
    end
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    check("t3_release_valid", 32'(a_out_valid), 32'd0);
    check("t3_release_inrdy", 32'(a_in_ready), 32'd1);
    run_a(8'd77, 1'b0, 12'h077, "t3_next");

    // Asynchronous reset mid-conversion.
    a_in_valid = 1'b1; a_din = 8'd200; a_xs3_en = 1'b0;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t4_rst_valid", 32'(a_out_valid), 32'd0);
    check("t4_rst_dout", 32'(a_dout), 32'd0);
    check("t4_rst_inrdy", 32'(a_in_ready), 32'd1);
    check("t4_rst_busy", 32'(a_busy), 32'd0);
    #4 rst_n = 1'b1;
    @(posedge clk); #1;
    run_a(8'd42, 1'b0, 12'h042, "t4_after");

    // Back-to-back with in_valid held high.
    ops  = '{8'd1, 8'd10, 8'd100};
    exps = '{12'h001, 12'h010, 12'h100};
    a_out_ready = 1'b1; a_xs3_en = 1'b0;
    a_in_valid = 1'b1; a_din = ops[0];
    k_acc = 0; k_out = 0; last = 0; cyc = 0;
    while (k_out < 3 && cyc < 80) begin
      acc = a_in_ready && a_in_valid;
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        k_acc++;
        if (k_acc < 3) a_din = ops[k_acc];
        else a_in_valid = 1'b0;
      end
      if (a_out_valid) begin
        check("t5_dout", 32'(a_dout), 32'(exps[k_out]));
        if (k_out > 0) check("t5_interval", 32'(cyc - last), 32'd10);
        last = cyc;
        k_out++;
      end
    end
    a_in_valid = 1'b0;
    check("t5_count", 32'(k_out), 32'd3);

    // Random regression on the N=12 instance.
    sent = 0; recvd = 0; cyc = 0;
    b_in_valid = 1'b1;
    b_din = 12'($urandom_range(0, 4095));
    b_xs3_en = 1'($urandom_range(0, 1));
    b_out_ready = 1'($urandom_range(0, 3) != 0);
    while (recvd < 200 && cyc < 20000) begin
      @(negedge clk);
      fire_in  = b_in_valid && b_in_ready;
      fire_out = b_out_valid && b_out_ready;
      if (fire_out) begin
        if (q.size() == 0) begin
          check("t6_spurious", 32'(b_dout), 32'hFFFF_FFFF);
        end else begin
          e = q.pop_front();
          check("t6_dout", 32'(b_dout), 32'(e));
        end
        recvd++;
      end
      if (fire_in) begin
        q.push_back(ref_dec(b_din, b_xs3_en));
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
      if (fire_in) begin
        b_in_valid = (sent < 200);
        b_din = 12'($urandom_range(0, 4095));
        b_xs3_en = 1'($urandom_range(0, 1));
      end
      b_out_ready = 1'($urandom_range(0, 3) != 0);
    end
    b_in_valid = 1'b0;
    check("t6_sent", 32'(sent), 32'd200);
    check("t6_recvd", 32'(recvd), 32'd200);
    check("t6_leftover", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
